// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, encodings and helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int INST_ADDR_W = 32;

  localparam logic [REG_ADDR_W-1:0]  ZERO_REG  = '0;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

  // Packed hold bus encodings for blocks that prefer a single hold field.
  typedef enum logic [1:0] {
    HOLD_NONE = 2'b00,
    HOLD_PC   = 2'b01,
    HOLD_ALL  = 2'b11
  } hold_e;

  // Per-cycle pipeline action, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    MODE_RUN        = 2'd0,
    MODE_LOAD_STALL = 2'd1,
    MODE_REDIRECT   = 2'd2,
    MODE_HOLD       = 2'd3
  } hz_mode_e;

  // How the load scoreboard advances on the next clock edge.
  typedef enum logic [1:0] {
    SB_ISSUE  = 2'd0,
    SB_BUBBLE = 2'd1,
    SB_FREEZE = 2'd2
  } sb_op_e;

  // A source register hits a tracked load when it is live and names the same rd.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rs,
                                   input logic                  v,
                                   input logic [REG_ADDR_W-1:0] a);
    return v && (rs != ZERO_REG) && (rs == a);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute/memory observations in, pipeline register controls out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0]  id_reg1_r_addr_i;
  logic [REG_ADDR_W-1:0]  id_reg2_r_addr_i;
  logic                   id_reg_w_ena_i;
  logic [REG_ADDR_W-1:0]  id_reg_w_addr_i;
  logic                   id_mem_r_ena_i;
  logic                   ex_jump_ena_i;
  logic [INST_ADDR_W-1:0] ex_jump_addr_i;
  logic                   mem_busy_i;

  logic                   jump_ena_o;
  logic [INST_ADDR_W-1:0] jump_addr_o;
  logic                   stall_pc_o;
  logic                   stall_if_id_o;
  logic                   stall_id_ex_o;
  logic                   stall_ex_mem_o;
  logic                   flush_if_id_o;
  logic                   flush_id_ex_o;
  logic [CNT_W-1:0]       stall_cnt_o;
  logic [CNT_W-1:0]       flush_cnt_o;

  modport master (
    output id_reg1_r_addr_i, id_reg2_r_addr_i, id_reg_w_ena_i, id_reg_w_addr_i,
           id_mem_r_ena_i, ex_jump_ena_i, ex_jump_addr_i, mem_busy_i,
    input  jump_ena_o, jump_addr_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
           stall_ex_mem_o, flush_if_id_o, flush_id_ex_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_reg1_r_addr_i, id_reg2_r_addr_i, id_reg_w_ena_i, id_reg_w_addr_i,
           id_mem_r_ena_i, ex_jump_ena_i, ex_jump_addr_i, mem_busy_i,
    output jump_ena_o, jump_addr_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
           stall_ex_mem_o, flush_if_id_o, flush_id_ex_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Two-entry load tracker (EX and MEM) with the load-use comparators.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  sb_op_e                op,
  input  logic                  issue_v,
  input  logic [REG_ADDR_W-1:0] issue_a,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hz
);

  logic                  ld_ex_v;
  logic [REG_ADDR_W-1:0] ld_ex_a;
  logic                  ld_mem_v;
  logic [REG_ADDR_W-1:0] ld_mem_a;

  // Without MEM forwarding a load still in MEM is also a hazard for decode.
  always_comb begin
    hz = reg_hit(rs1, ld_ex_v, ld_ex_a) || reg_hit(rs2, ld_ex_v, ld_ex_a);
    if (LOAD_USE_BUBBLES >= 2) begin
      hz = hz || reg_hit(rs1, ld_mem_v, ld_mem_a) || reg_hit(rs2, ld_mem_v, ld_mem_a);
    end
  end

  // Loads march EX -> MEM; a bubble or squash enters EX as an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ex_v  <= 1'b0;
      ld_ex_a  <= ZERO_REG;
      ld_mem_v <= 1'b0;
      ld_mem_a <= ZERO_REG;
    end else begin
      case (op)
        SB_ISSUE: begin
          ld_mem_v <= ld_ex_v;
          ld_mem_a <= ld_ex_a;
          ld_ex_v  <= issue_v;
          ld_ex_a  <= issue_a;
        end
        SB_BUBBLE: begin
          ld_mem_v <= ld_ex_v;
          ld_mem_a <= ld_ex_a;
          ld_ex_v  <= 1'b0;
          ld_ex_a  <= ZERO_REG;
        end
        default: begin
          ld_mem_v <= ld_mem_v;
          ld_mem_a <= ld_mem_a;
          ld_ex_v  <= ld_ex_v;
          ld_ex_a  <= ld_ex_a;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: hold, redirect and load-use stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  hz_mode_e               mode;
  sb_op_e                 sb_op;
  logic                   hz;
  logic                   issue_v;
  logic                   pend_jump;
  logic [INST_ADDR_W-1:0] pend_addr;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  assign issue_v = bus.id_mem_r_ena_i && bus.id_reg_w_ena_i && (bus.id_reg_w_addr_i != ZERO_REG);

  hazard_scoreboard #(
    .LOAD_USE_BUBBLES(LOAD_USE_BUBBLES)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .op     (sb_op),
    .issue_v(issue_v),
    .issue_a(bus.id_reg_w_addr_i),
    .rs1    (bus.id_reg1_r_addr_i),
    .rs2    (bus.id_reg2_r_addr_i),
    .hz     (hz)
  );

  // Pick this cycle's action; reset forces the quiet RUN controls.
  always_comb begin
    mode  = MODE_RUN;
    sb_op = SB_ISSUE;
    if (rst) begin
      mode = MODE_RUN;
    end else if (bus.mem_busy_i) begin
      mode = MODE_HOLD;
    end else if (bus.ex_jump_ena_i || pend_jump) begin
      mode = MODE_REDIRECT;
    end else if (hz) begin
      mode = MODE_LOAD_STALL;
    end
    case (mode)
      MODE_HOLD:       sb_op = SB_FREEZE;
      MODE_REDIRECT:   sb_op = SB_BUBBLE;
      MODE_LOAD_STALL: sb_op = SB_BUBBLE;
      default:         sb_op = SB_ISSUE;
    endcase
  end

  // Decode the action into the register stall/flush/redirect controls.
  always_comb begin
    bus.jump_ena_o     = 1'b0;
    bus.jump_addr_o    = ZERO_WORD;
    bus.stall_pc_o     = 1'b0;
    bus.stall_if_id_o  = 1'b0;
    bus.stall_id_ex_o  = 1'b0;
    bus.stall_ex_mem_o = 1'b0;
    bus.flush_if_id_o  = 1'b0;
    bus.flush_id_ex_o  = 1'b0;
    case (mode)
      MODE_HOLD: begin
        bus.stall_pc_o     = 1'b1;
        bus.stall_if_id_o  = 1'b1;
        bus.stall_id_ex_o  = 1'b1;
        bus.stall_ex_mem_o = 1'b1;
      end
      MODE_REDIRECT: begin
        bus.jump_ena_o    = 1'b1;
        bus.jump_addr_o   = bus.ex_jump_ena_i ? bus.ex_jump_addr_i : pend_addr;
        bus.flush_if_id_o = 1'b1;
        bus.flush_id_ex_o = 1'b1;
      end
      MODE_LOAD_STALL: begin
        bus.stall_pc_o    = 1'b1;
        bus.stall_if_id_o = 1'b1;
        bus.flush_id_ex_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Remember a jump resolved while memory held the pipe; the latest one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_jump <= 1'b0;
      pend_addr <= ZERO_WORD;
    end else if (mode == MODE_HOLD && bus.ex_jump_ena_i) begin
      pend_jump <= 1'b1;
      pend_addr <= bus.ex_jump_addr_i;
    end else if (mode == MODE_REDIRECT) begin
      pend_jump <= 1'b0;
    end
  end

  // Saturating stall and flush cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mode == MODE_LOAD_STALL && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (mode == MODE_REDIRECT && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives one decode/EX/MEM stream into a forwarding (1 bubble) and a
// non-forwarding (2 bubble, 3-bit counters) controller and checks both.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        we = 1'b0;
  logic [4:0]  rd = '0;
  logic        ld = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jaddr = '0;
  logic        busy = 1'b0;

  int assert_count = 0;
  int fail_count = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus_a ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  bus_b ();

  assign bus_a.id_reg1_r_addr_i = rs1;
  assign bus_a.id_reg2_r_addr_i = rs2;
  assign bus_a.id_reg_w_ena_i   = we;
  assign bus_a.id_reg_w_addr_i  = rd;
  assign bus_a.id_mem_r_ena_i   = ld;
  assign bus_a.ex_jump_ena_i    = jmp;
  assign bus_a.ex_jump_addr_i   = jaddr;
  assign bus_a.mem_busy_i       = busy;
  assign bus_b.id_reg1_r_addr_i = rs1;
  assign bus_b.id_reg2_r_addr_i = rs2;
  assign bus_b.id_reg_w_ena_i   = we;
  assign bus_b.id_reg_w_addr_i  = rd;
  assign bus_b.id_mem_r_ena_i   = ld;
  assign bus_b.ex_jump_ena_i    = jmp;
  assign bus_b.ex_jump_addr_i   = jaddr;
  assign bus_b.mem_busy_i       = busy;

  pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic w,
                               input logic [4:0] d, input logic l, input logic j,
                               input logic [31:0] ja, input logic b);
    @(negedge clk);
    rs1 = r1; rs2 = r2; we = w; rd = d; ld = l; jmp = j; jaddr = ja; busy = b;
  endtask

  // Reference model: per design, the rd of the last two loads that entered EX
  // (most recent first, 0 = no load), pending jump and the two counters.
  logic [4:0]  hist [2][2];
  bit          pend [2];
  logic [31:0] paddr [2];
  longint      scnt [2];
  longint      fcnt [2];
  int          lub [2] = '{1, 2};
  longint      cmax [2] = '{64'hFFFF_FFFF, 64'd7};

  initial begin
    logic [4:0]  n_hist [2][2];
    bit          n_pend [2];
    logic [31:0] n_paddr [2];
    longint      n_scnt [2];
    longint      n_fcnt [2];
    logic [6:0]  e_ctrl;
    logic [31:0] e_addr;
    logic [6:0]  a_ctrl;
    logic [31:0] a_addr;
    logic [63:0] a_scnt;
    logic [63:0] a_fcnt;
    logic [4:0]  push;
    bit          hit;
    string       tag;
    for (int k = 0; k < 2; k++) begin
      hist[k][0] = '0; hist[k][1] = '0; pend[k] = 0; paddr[k] = '0; scnt[k] = 0; fcnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        tag = (k == 0) ? "a" : "b";
        if (rst) begin
          hist[k][0] = '0; hist[k][1] = '0; pend[k] = 0; paddr[k] = '0; scnt[k] = 0; fcnt[k] = 0;
        end
        n_hist[k][0] = hist[k][0];
        n_hist[k][1] = hist[k][1];
        n_pend[k] = pend[k];
        n_paddr[k] = paddr[k];
        n_scnt[k] = scnt[k];
        n_fcnt[k] = fcnt[k];
        e_ctrl = '0;
        e_addr = '0;
        hit = 0;
        for (int j = 0; j < lub[k]; j++) begin
          if (hist[k][j] != 0 && (rs1 == hist[k][j] || rs2 == hist[k][j])) hit = 1;
        end
        if (rst) begin
          e_ctrl = '0;
        end else if (busy) begin
          e_ctrl = 7'b0111100;
          if (jmp) begin
            n_pend[k] = 1;
            n_paddr[k] = jaddr;
          end
        end else if (jmp || pend[k]) begin
          e_ctrl = 7'b1000011;
          e_addr = jmp ? jaddr : paddr[k];
          n_pend[k] = 0;
          n_hist[k][1] = hist[k][0];
          n_hist[k][0] = '0;
          if (fcnt[k] < cmax[k]) n_fcnt[k] = fcnt[k] + 1;
        end else if (hit) begin
          e_ctrl = 7'b0110001;
          n_hist[k][1] = hist[k][0];
          n_hist[k][0] = '0;
          if (scnt[k] < cmax[k]) n_scnt[k] = scnt[k] + 1;
        end else begin
          push = (ld && we && rd != 0) ? rd : 5'd0;
          n_hist[k][1] = hist[k][0];
          n_hist[k][0] = push;
        end
        if (k == 0) begin
          a_ctrl = {bus_a.jump_ena_o, bus_a.stall_pc_o, bus_a.stall_if_id_o, bus_a.stall_id_ex_o,
                    bus_a.stall_ex_mem_o, bus_a.flush_if_id_o, bus_a.flush_id_ex_o};
          a_addr = bus_a.jump_addr_o;
          a_scnt = 64'(bus_a.stall_cnt_o);
          a_fcnt = 64'(bus_a.flush_cnt_o);
        end else begin
          a_ctrl = {bus_b.jump_ena_o, bus_b.stall_pc_o, bus_b.stall_if_id_o, bus_b.stall_id_ex_o,
                    bus_b.stall_ex_mem_o, bus_b.flush_if_id_o, bus_b.flush_id_ex_o};
          a_addr = bus_b.jump_addr_o;
          a_scnt = 64'(bus_b.stall_cnt_o);
          a_fcnt = 64'(bus_b.flush_cnt_o);
        end
        checkOutput({"ctrl_", tag}, 64'(a_ctrl), 64'(e_ctrl));
        checkOutput({"jump_addr_", tag}, 64'(a_addr), 64'(e_addr));
        checkOutput({"stall_cnt_", tag}, a_scnt, 64'(scnt[k]));
        checkOutput({"flush_cnt_", tag}, a_fcnt, 64'(fcnt[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        hist[k][0] = n_hist[k][0];
        hist[k][1] = n_hist[k][1];
        pend[k] = n_pend[k];
        paddr[k] = n_paddr[k];
        scnt[k] = n_scnt[k];
        fcnt[k] = n_fcnt[k];
      end
    end
  end

  // Directed program with literal expectations at the interesting cycles.
  initial begin
    $display("[TB] start");
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    #3;
    checkOutput("rst_masks_busy", 64'(bus_a.stall_pc_o), 64'd0);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;

    applyStimulus(5'd2, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("lu_stall_a", 64'(bus_a.stall_pc_o), 64'd1);
    checkOutput("lu_stall_b", 64'(bus_b.stall_pc_o), 64'd1);
    applyStimulus(5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("lu_second_a", 64'(bus_a.stall_pc_o), 64'd0);
    checkOutput("lu_second_b", 64'(bus_b.flush_id_ex_o), 64'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("lu_cnt_a", 64'(bus_a.stall_cnt_o), 64'd1);
    checkOutput("lu_cnt_b", 64'(bus_b.stall_cnt_o), 64'd2);

    applyStimulus(5'd2, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("x0_load_a", 64'(bus_a.stall_pc_o), 64'd0);

    applyStimulus(5'd2, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(5'd7, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 32'h100, 1'b0);
    #3;
    checkOutput("jmp_ena_a", 64'(bus_a.jump_ena_o), 64'd1);
    checkOutput("jmp_addr_a", 64'(bus_a.jump_addr_o), 64'h100);
    checkOutput("jmp_flush_a", 64'({bus_a.flush_if_id_o, bus_a.flush_id_ex_o, bus_a.stall_pc_o}), 64'b110);
    applyStimulus(5'd7, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("dropped_load_a", 64'(bus_a.stall_pc_o), 64'd0);
    checkOutput("jmp_fcnt_a", 64'(bus_a.flush_cnt_o), 64'd1);
    checkOutput("jmp_scnt_a", 64'(bus_a.stall_cnt_o), 64'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h200, 1'b1);
    #3;
    checkOutput("hold_no_jump_a", 64'(bus_a.jump_ena_o), 64'd0);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    #3;
    checkOutput("hold_stall_a", 64'(bus_a.stall_ex_mem_o), 64'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("pend_ena_a", 64'(bus_a.jump_ena_o), 64'd1);
    checkOutput("pend_addr_a", 64'(bus_a.jump_addr_o), 64'h200);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("pend_fcnt_a", 64'(bus_a.flush_cnt_o), 64'd2);

    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h300, 1'b1);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    #3;
    checkOutput("rst_hold_a", 64'(bus_a.stall_ex_mem_o), 64'd0);
    checkOutput("rst_fcnt_a", 64'(bus_a.flush_cnt_o), 64'd0);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #3;
    checkOutput("rst_no_redirect_a", 64'(bus_a.jump_ena_o), 64'd0);
    checkOutput("rst_scnt_a", 64'(bus_a.stall_cnt_o), 64'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'd2, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(5'd3, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(5'd3, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("sat_scnt_a", 64'(bus_a.stall_cnt_o), 64'd5);
    checkOutput("sat_scnt_b", 64'(bus_b.stall_cnt_o), 64'd7);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'(i * 4 + 32'h400), 1'b0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("sat_fcnt_a", 64'(bus_a.flush_cnt_o), 64'd8);
    checkOutput("sat_fcnt_b", 64'(bus_b.flush_cnt_o), 64'd7);

    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Watches the instruction in decode, the jump request from execute, and the data-memory busy signal.
- Drives the stall, flush and redirect controls for the PC, if_id, id_ex and ex_mem registers.
- Keeps a small load scoreboard so load-use hazards are detected; two saturating performance counters record stall and flush cycles.

Parameters:
- LOAD_USE_BUBBLES, 1: bubbles inserted after a load. 1 means MEM→EX forwarding exists; 2 means no MEM forwarding. Only 1 and 2 are legal.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- id_reg1_r_addr_i  in  5  rs1 read by the decode instruction; 0 = unused
- id_reg2_r_addr_i  in  5  rs2 read by the decode instruction; 0 = unused
- id_reg_w_ena_i  in  1  decode instruction writes rd
- id_reg_w_addr_i  in  5  decode rd
- id_mem_r_ena_i  in  1  decode instruction is a load
- ex_jump_ena_i  in  1  taken branch/jump resolved in EX
- ex_jump_addr_i  in  32  jump target
- mem_busy_i  in  1  data memory not ready; freeze the pipeline
- jump_ena_o  out  1  redirect PC this cycle
- jump_addr_o  out  32  redirect target
- stall_pc_o  out  1  hold PC
- stall_if_id_o  out  1  hold if_id
- stall_id_ex_o  out  1  hold id_ex
- stall_ex_mem_o  out  1  hold ex_mem
- flush_if_id_o  out  1  load NOP into if_id
- flush_id_ex_o  out  1  load NOP into id_ex
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles
- flush_cnt_o  out  CNT_W  saturating count of redirect cycles

Behaviour:
- Reset: while rst=1, all 1-bit outputs are 0, jump_addr_o=0, both counters are 0, the scoreboard is empty and pend_jump is clear.
- Control outputs are combinational from the inputs plus registered state. There is zero-cycle latency from a hazard to its stall/flush.
- Scoreboard registers:
  - ld_ex_v / ld_ex_a: load currently in EX.
  - ld_mem_v / ld_mem_a: load currently in MEM.
  - A load to x0 never sets a valid bit.
- Pending-jump registers: pend_jump, pend_addr.
- Hazard: hz = 1 when a nonzero id_reg1_r_addr_i or id_reg2_r_addr_i equals ld_ex_a with ld_ex_v=1.
  - If LOAD_USE_BUBBLES=2, a match against ld_mem_a with ld_mem_v=1 also sets hz.
- Priority per cycle: HOLD > REDIRECT > LOAD_STALL > RUN.
- HOLD (mem_busy_i=1):
  - All four stall outputs are 1; flushes and jump_ena_o are 0.
  - Scoreboard and counters do not change.
  - If ex_jump_ena_i=1, set pend_jump=1 and pend_addr=ex_jump_addr_i. A later jump arriving during the same hold overwrites pend_addr.
- REDIRECT (no hold, and ex_jump_ena_i or pend_jump):
  - jump_ena_o=1.
  - jump_addr_o = ex_jump_addr_i if ex_jump_ena_i, else pend_addr (a live jump wins).
  - flush_if_id_o=1 and flush_id_ex_o=1; stalls are 0.
  - Scoreboard shifts: ld_mem ← ld_ex, ld_ex ← empty.
  - pend_jump is cleared and flush_cnt increments.
  - hz is ignored, because the decode instruction is squashed.
- LOAD_STALL (no hold, no redirect, hz=1):
  - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1.
  - Scoreboard shifts with ld_ex ← empty (a bubble).
  - stall_cnt increments.
- RUN:
  - All controls are 0.
  - Scoreboard shifts with ld_ex_v ← id_mem_r_ena_i & id_reg_w_ena_i & (id_reg_w_addr_i≠0) and ld_ex_a ← id_reg_w_addr_i.
- When not hold, jump_addr_o = 0 unless jump_ena_o=1. During hold, jump_addr_o = 0.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-hold discards the pending jump and the scoreboard immediately.
- With LOAD_USE_BUBBLES=2, a dependent instruction directly behind a load stalls for exactly 2 cycles, because the scoreboard advance clears the match.

Decomposition:
- Shared defines header (existing `define` file):
  - ZERO_REG, ZERO_WORD, INST_ADDR and REG_ADDR widths.
  - New HOLD_NONE/HOLD_PC/HOLD_ALL encodings, if other blocks want a packed hold bus.
- One natural sub-module: hazard_scoreboard. It holds the two-entry load pipeline, the comparators and the shift/clear controls. The top level keeps the priority logic, pending jump and counters.

Test Plan:
- Load x5 then `add x6,x5,x1` back-to-back, LOAD_USE_BUBBLES=1 → exactly 1 cycle of stall_pc/stall_if_id/flush_id_ex; stall_cnt_o=1.
- Same sequence with LOAD_USE_BUBBLES=2 → 2 stall cycles, stall_cnt_o=2. `lw x0,...` followed by a use of x0 → no stall.
- ex_jump_ena_i=1, addr 0x0000_0100 → same cycle jump_ena_o=1, jump_addr_o=0x100, both flushes=1, flush_cnt_o=1. A load then in EX is dropped, so its dependant does not stall.
- mem_busy_i high for 3 cycles; jump to 0x200 arrives in cycle 2 → 3 cycles of all stalls with no redirect. On the first non-busy cycle, jump_ena_o=1 and jump_addr_o=0x200.
- Load-use hazard and ex_jump_ena_i in the same cycle → redirect only: stall_cnt unchanged, flush_cnt +1.
- rst pulsed while pend_jump=1 and mem_busy_i=1, then released with mem_busy_i=0 → no redirect, counters 0, all outputs 0. A counter preloaded near max via forced stalls stays at all-ones.
